// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Arbitrates the register file's single write port between the
//             pipeline MEM/WB stage and the long-latency multiply/divide unit.
//             The pipeline always wins. MDU results wait in a small FIFO and
//             drain on cycles where the pipeline does not write.
//             A starvation counter requests a pipeline stall, so that buffered
//             results always retire.
//  Option   : WB_BYPASS_EN - when defined, a lookup over pending FIFO entries
//             lets forwarding logic see results that have not yet retired.
//             When undefined, qry_rn is ignored and qry_hit / qry_d read 0.
//  Ports    : clk        rising-edge clock
//             clrn       asynchronous active-low reset
//             pipe_*     pipeline write request (we / wn / d)
//             mdu_*      MDU result handshake (valid / wn / d / ready)
//             rf_*       register-file write port (combinational)
//             stall_req  registered stall request to the hazard unit
//             pend_cnt   number of occupied FIFO entries
//             qry_*      forwarding lookup (rn in, hit / d out)
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH      = 4,   // FIFO entries, power of two, >= 2
    parameter int AW         = 2,   // log2(DEPTH)
    parameter int STARVE_MAX = 8    // 1..255
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_wn,
    input  logic [31:0]   pipe_d,
    input  logic          mdu_valid,
    input  logic [4:0]    mdu_wn,
    input  logic [31:0]   mdu_d,
    output logic          mdu_ready,
    output logic          rf_we,
    output logic [4:0]    rf_wn,
    output logic [31:0]   rf_d,
    output logic          stall_req,
    output logic [AW:0]   pend_cnt,
    input  logic [4:0]    qry_rn,
    output logic          qry_hit,
    output logic [31:0]   qry_d
);

    localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);

    // ------------------------------------------------------------------
    // FIFO storage and state
    // ------------------------------------------------------------------
    logic [4:0]    fifo_wn [DEPTH];
    logic [31:0]   fifo_d  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    starve_cnt;
    logic [7:0]    starve_nxt;
    logic          stall_q;

    logic          empty;
    logic          full;
    logic          pipe_sel;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    // A write to r0 is not a real write, so it never blocks draining.
    assign pipe_sel = pipe_we && (pipe_wn != 5'd0);
    // Results for r0 complete the handshake but are dropped here.
    assign push     = mdu_valid && !full && (mdu_wn != 5'd0);
    assign pop      = !pipe_sel && !empty;

    assign mdu_ready = !full;
    assign pend_cnt  = count;
    assign stall_req = stall_q;

    // ------------------------------------------------------------------
    // Write-port mux. The data path keeps following the pipeline during
    // reset; only the enable is gated by clrn.
    // ------------------------------------------------------------------
    always_comb begin
        rf_we = 1'b0;
        rf_wn = 5'd0;
        rf_d  = 32'd0;
        if (pipe_sel) begin
            rf_we = clrn;
            rf_wn = pipe_wn;
            rf_d  = pipe_d;
        end else if (!empty) begin
            rf_we = clrn;
            rf_wn = fifo_wn[rd_ptr];
            rf_d  = fifo_d[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles with pending entries
    // but no pop, saturating at the limit.
    // ------------------------------------------------------------------
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || empty) begin
            starve_nxt = 8'd0;
        end else if (starve_cnt < STARVE_LIM) begin
            starve_nxt = starve_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and stall request
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= 8'd0;
            stall_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
            // Rises on the edge the counter reaches the limit. Any pop (or an
            // empty FIFO) zeroes the counter, which drops the request.
            stall_q    <= (starve_nxt == STARVE_LIM);
        end
    end

    // Storage is deliberately left out of reset; entries only become
    // visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wn[wr_ptr] <= mdu_wn;
            fifo_d[wr_ptr]  <= mdu_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding lookup
    // ------------------------------------------------------------------
`ifdef WB_BYPASS_EN
    logic [AW-1:0] byp_idx;

    // Walk entries oldest to youngest so the last match is the youngest.
    always_comb begin
        qry_hit = 1'b0;
        qry_d   = 32'd0;
        byp_idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = rd_ptr + AW'(k);
            if (((AW+1)'(k) < count) && (qry_rn != 5'd0) &&
                (fifo_wn[byp_idx] == qry_rn)) begin
                qry_hit = 1'b1;
                qry_d   = fifo_d[byp_idx];
            end
        end
    end
`else
    logic unused_qry;
    assign unused_qry = &{1'b0, qry_rn};
    assign qry_hit    = 1'b0;
    assign qry_d      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Directed self-checking bench for wb_arbiter (DEPTH=4,
//             STARVE_MAX=8). Expected values are hand-computed per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic        pipe_we;
    logic [4:0]  pipe_wn;
    logic [31:0] pipe_d;
    logic        mdu_valid;
    logic [4:0]  mdu_wn;
    logic [31:0] mdu_d;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic        stall_req;
    logic [2:0]  pend_cnt;
    logic [4:0]  qry_rn;
    logic        qry_hit;
    logic [31:0] qry_d;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(.DEPTH(4), .AW(2), .STARVE_MAX(8)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .pipe_we   (pipe_we),
        .pipe_wn   (pipe_wn),
        .pipe_d    (pipe_d),
        .mdu_valid (mdu_valid),
        .mdu_wn    (mdu_wn),
        .mdu_d     (mdu_d),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_wn     (rf_wn),
        .rf_d      (rf_d),
        .stall_req (stall_req),
        .pend_cnt  (pend_cnt),
        .qry_rn    (qry_rn),
        .qry_hit   (qry_hit),
        .qry_d     (qry_d)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        clrn = 1'b0; pipe_we = 1'b0; pipe_wn = 5'd0; pipe_d = 32'd0;
        mdu_valid = 1'b0; mdu_wn = 5'd0; mdu_d = 32'd0; qry_rn = 5'd0;

        // ---------------- reset and idle ----------------
        tick();
        pipe_we = 1'b1; pipe_wn = 5'd3; pipe_d = 32'h33;
        settle();
        check("rst_rf_we_gated", rf_we, 0);
        check("rst_rf_wn_follows", rf_wn, 3);
        pipe_we = 1'b0; pipe_wn = 5'd0; pipe_d = 32'd0;
        tick();
        clrn = 1'b1;
        tick();
        check("idle_ready", mdu_ready, 1);
        check("idle_pend", pend_cnt, 0);
        check("idle_stall", stall_req, 0);
        check("idle_rf_we", rf_we, 0);

        // ---------------- pipe priority and drain ----------------
        pipe_we = 1'b1; pipe_wn = 5'd3; pipe_d = 32'h33;
        mdu_valid = 1'b1; mdu_wn = 5'd5; mdu_d = 32'hAAAA0005;
        settle();
        check("pri_c0_wn", rf_wn, 3);
        check("pri_c0_d", rf_d, 32'h33);
        tick();
        mdu_valid = 1'b0;
        settle();
        check("pri_c1_wn", rf_wn, 3);
        check("pri_c1_pend", pend_cnt, 1);
        tick();
        pipe_we = 1'b0;
        settle();
        check("pri_c2_we", rf_we, 1);
        check("pri_c2_wn", rf_wn, 5);
        check("pri_c2_d", rf_d, 32'hAAAA0005);
        tick();
        check("pri_c3_we", rf_we, 0);
        check("pri_c3_wn", rf_wn, 0);
        check("pri_c3_pend", pend_cnt, 0);

        // ---------------- full and backpressure ----------------
        pipe_we = 1'b1; pipe_wn = 5'd3; pipe_d = 32'h33;
        for (int i = 1; i <= 5; i++) begin
            mdu_valid = 1'b1; mdu_wn = 5'(i); mdu_d = 32'h100 + 32'(i);
            settle();
            check($sformatf("full_ready_%0d", i), mdu_ready, (i <= 4) ? 1 : 0);
            check($sformatf("full_pend_%0d", i), pend_cnt, (i <= 4) ? i - 1 : 4);
            tick();
        end
        check("full_hold_pend", pend_cnt, 4);
        check("full_hold_ready", mdu_ready, 0);
        check("full_hold_pipe", rf_wn, 3);
        pipe_we = 1'b0;
        settle();
        check("drain0_wn", rf_wn, 1);
        check("drain0_d", rf_d, 32'h101);
        tick();
        check("drain1_wn", rf_wn, 2);
        check("drain1_pend", pend_cnt, 3);
        check("drain1_ready", mdu_ready, 1);
        tick();
        mdu_valid = 1'b0;
        settle();
        check("drain2_wn", rf_wn, 3);
        check("drain2_pend", pend_cnt, 3);
        tick();
        check("drain3_wn", rf_wn, 4);
        check("drain3_pend", pend_cnt, 2);
        tick();
        check("drain4_wn", rf_wn, 5);
        check("drain4_d", rf_d, 32'h105);
        check("drain4_pend", pend_cnt, 1);
        tick();
        check("drain5_we", rf_we, 0);
        check("drain5_pend", pend_cnt, 0);

        // ---------------- register zero ----------------
        mdu_valid = 1'b1; mdu_wn = 5'd0; mdu_d = 32'hDEAD;
        settle();
        check("r0_ready", mdu_ready, 1);
        tick();
        mdu_valid = 1'b0;
        settle();
        check("r0_pend", pend_cnt, 0);
        check("r0_we", rf_we, 0);
        pipe_we = 1'b1; pipe_wn = 5'd3; pipe_d = 32'h33;
        mdu_valid = 1'b1; mdu_wn = 5'd9; mdu_d = 32'h99;
        tick();
        mdu_valid = 1'b0;
        pipe_we = 1'b1; pipe_wn = 5'd0; pipe_d = 32'hBEEF;
        settle();
        check("pwn0_we", rf_we, 1);
        check("pwn0_wn", rf_wn, 9);
        check("pwn0_d", rf_d, 32'h99);
        tick();
        check("pwn0_pend", pend_cnt, 0);
        check("pwn0_we_after", rf_we, 0);

        // ---------------- starvation ----------------
        pipe_we = 1'b1; pipe_wn = 5'd3; pipe_d = 32'h33;
        mdu_valid = 1'b1; mdu_wn = 5'd10; mdu_d = 32'hA0;
        tick();
        mdu_valid = 1'b0;
        settle();
        check("starve_k0", stall_req, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("starve_k%0d", k), stall_req, (k >= 8) ? 1 : 0);
        end
        check("starve_pipe_wins", rf_wn, 3);
        pipe_we = 1'b0;
        settle();
        check("starve_pop_wn", rf_wn, 10);
        check("starve_still_high", stall_req, 1);
        tick();
        check("starve_cleared", stall_req, 0);
        check("starve_pend", pend_cnt, 0);

        // ---------------- reset mid-drain ----------------
        pipe_we = 1'b1; pipe_wn = 5'd3;
        mdu_valid = 1'b1; mdu_wn = 5'd11; mdu_d = 32'hB1;
        tick();
        mdu_wn = 5'd12; mdu_d = 32'hB2;
        tick();
        mdu_valid = 1'b0; pipe_we = 1'b0;
        settle();
        check("mid_pend", pend_cnt, 2);
        check("mid_wn", rf_wn, 11);
        #1;
        clrn = 1'b0;
        #1;
        check("mid_rst_pend", pend_cnt, 0);
        check("mid_rst_ready", mdu_ready, 1);
        check("mid_rst_we", rf_we, 0);
        tick();
        clrn = 1'b1;
        tick();
        check("mid_after_we", rf_we, 0);
        check("mid_after_pend", pend_cnt, 0);

        // ---------------- bypass lookup ----------------
        pipe_we = 1'b1; pipe_wn = 5'd3; pipe_d = 32'h33;
        mdu_valid = 1'b1; mdu_wn = 5'd7; mdu_d = 32'h11;
        tick();
        mdu_d = 32'h22;
        tick();
        mdu_wn = 5'd8; mdu_d = 32'h88;
        tick();
        mdu_valid = 1'b0;
        qry_rn = 5'd7;
        settle();
`ifdef WB_BYPASS_EN
        check("byp_r7_hit", qry_hit, 1);
        check("byp_r7_d", qry_d, 32'h22);
        qry_rn = 5'd8;
        settle();
        check("byp_r8_d", qry_d, 32'h88);
        qry_rn = 5'd12;
        settle();
        check("byp_r12_hit", qry_hit, 0);
`else
        check("byp_off_hit", qry_hit, 0);
        check("byp_off_d", qry_d, 0);
`endif
        qry_rn = 5'd0;
        settle();
        check("byp_r0_hit", qry_hit, 0);
        pipe_we = 1'b0;
        tick();
        tick();
        tick();
        check("byp_drained", pend_cnt, 0);
        qry_rn = 5'd7;
        settle();
        check("byp_empty_hit", qry_hit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter in front of the CPU register file's single write port. Pipeline MEM/WB results and out-of-order results from the long-latency multiply/divide unit (MDU) compete for that port. The arbiter gives the pipeline absolute priority and buffers MDU results in a small FIFO, draining it on idle write cycles. A starvation guard requests a pipeline stall so buffered results always retire, and an optional bypass lookup exposes pending results to the forwarding logic.

## Interface
- DEPTH, 4, FIFO entries for MDU results; power of two, ≥2
- AW, 2, log2(DEPTH)
- STARVE_MAX, 8, consecutive un-drained cycles before a stall is requested; range 1..255
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- pipe_we  in  1  pipeline write-back enable
- pipe_wn  in  5  pipeline destination register
- pipe_d  in  32  pipeline write data
- mdu_valid  in  1  MDU result valid
- mdu_wn  in  5  MDU destination register
- mdu_d  in  32  MDU result
- mdu_ready  out  1  FIFO can accept; equals !full
- rf_we  out  1  register-file write enable (combinational)
- rf_wn  out  5  register-file write number (combinational)
- rf_d  out  32  register-file write data (combinational)
- stall_req  out  1  request to the hazard unit to hold pipe_we low (registered)
- pend_cnt  out  AW+1  number of FIFO entries occupied
- qry_rn  in  5  forwarding query register number
- qry_hit  out  1  a pending FIFO entry targets qry_rn
- qry_d  out  32  data of the youngest matching entry

## Operation
- pipe_sel = pipe_we && pipe_wn!=0. When pipe_sel is 1: rf_we=1, rf_wn=pipe_wn, rf_d=pipe_d, and the FIFO is not popped.
- Otherwise, if the FIFO is non-empty: rf_we=1, rf_wn/rf_d come from the FIFO head, and the FIFO pops on this edge.
- Otherwise rf_we=0, rf_wn=0, rf_d=0.
- pipe_we with pipe_wn=0 counts as no write. It does not block draining.
- Push on mdu_valid && mdu_ready && mdu_wn!=0.
  - mdu_wn=0 with mdu_valid is accepted and discarded: no push, but the handshake completes.
  - mdu_valid while full is not accepted. The MDU holds its result.
- A push and a pop in the same cycle leave pend_cnt unchanged. A push while full and popping in the same cycle is not accepted, because mdu_ready reflects the registered full flag.
- Ordering: the hazard unit guarantees no pipeline write targets a register with a pending FIFO entry. The arbiter does not check this.
- Starvation counter:
  - Increments on each cycle where the FIFO is non-empty and no pop occurs. Resets to 0 on any pop or when the FIFO is empty. Saturates at STARVE_MAX.
  - stall_req is set on the edge where the counter reaches STARVE_MAX. It clears on the edge after a pop.
  - If pipe_we stays asserted during stall_req, the pipeline still wins and stall_req stays high.
- Reset (clrn=0, any time, mid-drain included):
  - FIFO pointers, pend_cnt and the starvation counter go to 0, so mdu_ready=1 and stall_req=0.
  - All pending entries are lost. FIFO data storage is not cleared.
  - Combinational rf_* outputs still follow pipe_* during reset, but rf_we is forced to 0 while clrn=0.

## Timing
- Pipeline path has zero latency: pipe_* to rf_* is combinational, and the register file writes on the same edge.
- An MDU result pushed at edge N is at the head at N+1 if the FIFO was empty. It retires on the first edge at or after N+1 with pipe_sel=0.
- pend_cnt and mdu_ready update on the edge after a push or pop.
- With a continuous pipeline write stream, stall_req rises STARVE_MAX cycles after the FIFO becomes non-empty.

## Configuration
- WB_BYPASS_EN defined:
  - qry_hit=1 when qry_rn!=0 and some occupied entry has wn==qry_rn.
  - qry_d is the data of the most recently pushed such entry.
  - Both outputs are combinational over all occupied entries.
- WB_BYPASS_EN undefined: the qry_rn port is present but ignored, and qry_hit and qry_d are tied to 0. The comparator logic is not built.

## Test plan
- Reset and idle:
  - clrn low then high, with no inputs.
  - Expect mdu_ready=1, pend_cnt=0, stall_req=0, rf_we=0.
- Pipe priority and drain:
  - Push mdu_wn=5/0xAAAA0005 while pipe writes r3=0x33 for 2 cycles, then pipe_we=0.
  - Expect rf writes r3, r3, then r5=0xAAAA0005 on the first idle cycle, with pend_cnt 1→0.
- Full and backpressure (DEPTH=4):
  - Push 5 results (r1..r5) with pipe_we=1 continuously.
  - Expect mdu_ready=0 after the 4th push and r5 held.
  - Release the pipeline. Expect writes r1, r2, r3, r4, r5 in order, pend_cnt peaking at 4.
- Register zero:
  - mdu_wn=0 valid: handshake completes, pend_cnt stays 0.
  - pipe_we=1, pipe_wn=0 while 1 entry is pending: the entry drains the same cycle.
- Starvation:
  - STARVE_MAX=8, one entry pending, pipe_we held 1.
  - Expect stall_req=1 after 8 cycles.
  - Drop pipe_we. Expect a pop, then stall_req=0 on the next edge.
- Bypass (WB_BYPASS_EN):
  - Push r7=0x11, then r7=0x22, with the pipe busy. Set qry_rn=7.
  - Expect qry_hit=1 and qry_d=0x22.
  - qry_rn=0 gives qry_hit=0. Without the macro, qry_hit=0 always.
